// File: rtl/multicycle_control.sv
// Sequencing controller for the multi-cycle RV32I core. Steps each
// instruction through FETCH/DECODE/EXEC/MEM/WB, drives the datapath
// enables and mux selects, counts retired instructions and parks in
// TRAP on an unsupported opcode until reset.
module multicycle_control #(
    parameter int CNT_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [6:0]           opcode,
    input  logic                 inst_ready,
    input  logic                 mem_ready,
    input  logic                 taken,
    output logic                 inst_req,
    output logic                 ir_write,
    output logic                 pc_write,
    output logic [1:0]           pc_src,
    output logic [1:0]           alu_a_sel,
    output logic                 alu_b_sel,
    output logic [1:0]           alu_op,
    output logic                 mem_read,
    output logic                 mem_write,
    output logic                 reg_write,
    output logic [1:0]           wb_sel,
    output logic [2:0]           state,
    output logic                 trap,
    output logic [CNT_WIDTH-1:0] instret
);

    typedef enum logic [2:0] {
        FETCH  = 3'd0,
        DECODE = 3'd1,
        EXEC   = 3'd2,
        MEM    = 3'd3,
        WB     = 3'd4,
        TRAP   = 3'd5
    } state_t;

    typedef enum logic [3:0] {
        C_R, C_I, C_LOAD, C_STORE, C_BRANCH,
        C_JAL, C_JALR, C_LUI, C_AUIPC, C_ILLEGAL
    } class_t;

    state_t cur_state;
    state_t next_state;
    class_t dec_class;
    class_t inst_class;
    logic   retire;

    logic [1:0] exec_a_sel;
    logic       exec_b_sel;
    logic [1:0] exec_alu_op;

    assign state = cur_state;

    // Classify the raw opcode; only consulted while in DECODE.
    always_comb begin
        dec_class = C_ILLEGAL;
        case (opcode)
            7'b0110011: dec_class = C_R;
            7'b0010011: dec_class = C_I;
            7'b0000011: dec_class = C_LOAD;
            7'b0100011: dec_class = C_STORE;
            7'b1100011: dec_class = C_BRANCH;
            7'b1101111: dec_class = C_JAL;
            7'b1100111: dec_class = C_JALR;
            7'b0110111: dec_class = C_LUI;
            7'b0010111: dec_class = C_AUIPC;
            default:    dec_class = C_ILLEGAL;
        endcase
    end

    // Hold the instruction class so later states do not depend on opcode.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            inst_class <= C_ILLEGAL;
        else if (cur_state == DECODE)
            inst_class <= dec_class;
    end

    // ALU operand/op selection per class; shared by EXEC and WB so the
    // ALU result stays stable while it is being written back.
    always_comb begin
        exec_a_sel  = 2'd0;
        exec_b_sel  = 1'b0;
        exec_alu_op = 2'b00;
        case (inst_class)
            C_R:      begin exec_a_sel = 2'd0; exec_b_sel = 1'b0; exec_alu_op = 2'b10; end
            C_I:      begin exec_a_sel = 2'd0; exec_b_sel = 1'b1; exec_alu_op = 2'b10; end
            C_LOAD,
            C_STORE:  begin exec_a_sel = 2'd0; exec_b_sel = 1'b1; exec_alu_op = 2'b00; end
            C_BRANCH: begin exec_a_sel = 2'd0; exec_b_sel = 1'b0; exec_alu_op = 2'b01; end
            C_LUI:    begin exec_a_sel = 2'd2; exec_b_sel = 1'b1; exec_alu_op = 2'b00; end
            C_AUIPC:  begin exec_a_sel = 2'd1; exec_b_sel = 1'b1; exec_alu_op = 2'b00; end
            C_JALR:   begin exec_a_sel = 2'd0; exec_b_sel = 1'b1; exec_alu_op = 2'b00; end
            default:  begin exec_a_sel = 2'd0; exec_b_sel = 1'b0; exec_alu_op = 2'b00; end
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            cur_state <= FETCH;
        else
            cur_state <= next_state;
    end

    // Next-state and strobe decode; reset forces every strobe low so an
    // aborted instruction cannot leak a partial write.
    always_comb begin
        next_state = cur_state;
        inst_req   = 1'b0;
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        pc_src     = 2'd0;
        alu_a_sel  = 2'd0;
        alu_b_sel  = 1'b0;
        alu_op     = 2'b00;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        reg_write  = 1'b0;
        wb_sel     = 2'd0;
        retire     = 1'b0;
        case (cur_state)
            FETCH: begin
                inst_req = 1'b1;
                if (inst_ready) begin
                    ir_write   = 1'b1;
                    next_state = DECODE;
                end
            end
            DECODE: begin
                next_state = (dec_class == C_ILLEGAL) ? TRAP : EXEC;
            end
            EXEC: begin
                alu_a_sel = exec_a_sel;
                alu_b_sel = exec_b_sel;
                alu_op    = exec_alu_op;
                case (inst_class)
                    C_LOAD, C_STORE: next_state = MEM;
                    C_BRANCH: begin
                        pc_write   = 1'b1;
                        pc_src     = taken ? 2'd1 : 2'd0;
                        retire     = 1'b1;
                        next_state = FETCH;
                    end
                    default: next_state = WB;
                endcase
            end
            MEM: begin
                mem_read  = (inst_class == C_LOAD);
                mem_write = (inst_class == C_STORE);
                if (mem_ready) begin
                    if (inst_class == C_STORE) begin
                        pc_write   = 1'b1;
                        retire     = 1'b1;
                        next_state = FETCH;
                    end else begin
                        next_state = WB;
                    end
                end
            end
            WB: begin
                alu_a_sel  = exec_a_sel;
                alu_b_sel  = exec_b_sel;
                alu_op     = exec_alu_op;
                reg_write  = 1'b1;
                pc_write   = 1'b1;
                retire     = 1'b1;
                next_state = FETCH;
                case (inst_class)
                    C_LOAD:  wb_sel = 2'd1;
                    C_JAL:   begin wb_sel = 2'd2; pc_src = 2'd1; end
                    C_JALR:  begin wb_sel = 2'd2; pc_src = 2'd2; end
                    default: wb_sel = 2'd0;
                endcase
            end
            TRAP: begin
                next_state = TRAP;
            end
            default: begin
                next_state = FETCH;
            end
        endcase
        if (rst) begin
            inst_req  = 1'b0;
            ir_write  = 1'b0;
            pc_write  = 1'b0;
            pc_src    = 2'd0;
            alu_a_sel = 2'd0;
            alu_b_sel = 1'b0;
            alu_op    = 2'b00;
            mem_read  = 1'b0;
            mem_write = 1'b0;
            reg_write = 1'b0;
            wb_sel    = 2'd0;
            retire    = 1'b0;
        end
    end

    // TRAP is only left through reset, so the flag is sticky by construction.
    assign trap = (cur_state == TRAP) && !rst;

    // Retired-instruction counter, wrapping naturally at all-ones.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            instret <= '0;
        else if (retire)
            instret <= instret + CNT_WIDTH'(1);
    end

endmodule
